// File: rtl/instr_mem_pkg.sv
// Shared constants for the RV32I instruction memory: NOP encoding, boot program
// and a lookup helper that returns the reset image word for any index.
package instr_mem_pkg;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam int unsigned BOOT_LEN   = 3;

    localparam logic [31:0] BOOT_WORD0 = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] BOOT_WORD1 = 32'h00A0_0113;  // addi x2,x0,10
    localparam logic [31:0] BOOT_WORD2 = 32'h0020_81B3;  // add  x3,x1,x2

    localparam logic [31:0] RESET_OUT  = 32'h0000_0000;

    function automatic logic [31:0] boot_word(input int unsigned idx);
        logic [31:0] word;
        word = NOP_INSN;
        if (idx < BOOT_LEN) begin
            case (idx)
                0:       word = BOOT_WORD0;
                1:       word = BOOT_WORD1;
                2:       word = BOOT_WORD2;
                default: word = NOP_INSN;
            endcase
        end
        return word;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory with combinational fetch and a boot image restored by rst_n.
// Define IMEM_LOAD_PORT_EN to make the array writable; otherwise it is a ROM.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    output logic [31:0] instruction,
    output logic        addr_err,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      word_arr [DEPTH];
    logic [IDX_W-1:0] ridx;
    logic             rd_in_range;

`ifdef IMEM_LOAD_PORT_EN
    logic [31:0]      mem_reg [DEPTH];
    logic [IDX_W-1:0] widx;
    logic             wr_ok;
    logic             unused_waddr_lsb;

    assign widx             = waddr[IDX_W+1:2];
    // Out-of-range writes are dropped rather than wrapped onto a low word.
    assign wr_ok            = we && ((waddr >> (IDX_W + 2)) == 32'd0);
    assign unused_waddr_lsb = ^waddr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= boot_word(i);
            end
        end else if (wr_ok) begin
            mem_reg[widx] <= wdata;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ram_word
        assign word_arr[gi] = mem_reg[gi];
    end
`else
    logic unused_load_port;

    assign unused_load_port = ^{we, waddr, wdata, clk};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom_word
        assign word_arr[gi] = boot_word(gi);
    end
`endif

    assign ridx        = addr[IDX_W+1:2];
    assign rd_in_range = ((addr >> (IDX_W + 2)) == 32'd0);

    // Reset gates both outputs so a fetch during reset never looks valid.
    always_comb begin
        instruction = RESET_OUT;
        addr_err    = 1'b0;
        if (rst_n) begin
            instruction = rd_in_range ? word_arr[ridx] : NOP_INSN;
            addr_err    = (addr[1:0] != 2'b00) || !rd_in_range;
        end
    end

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: expected fetch results are queued as each
// address is driven and popped/compared once the combinational output settles.
module tb_instr_mem;

    localparam int DEPTH = 64;

    typedef struct {
        string       tag;
        logic [31:0] insn;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] instruction;
    logic        addr_err;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    int          n_checks;
    int          n_pass;

    instr_mem #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .instruction (instruction),
        .addr_err    (addr_err),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0000_0013;
        model_mem[0] = 32'h0050_0093;
        model_mem[1] = 32'h00A0_0113;
        model_mem[2] = 32'h0020_81B3;
    endtask

    // Drive one fetch address, queue its expectation, then check after settling.
    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_insn, input logic exp_err);
        exp_t e;
        exp_t got;
        addr = a;
        e.tag = tag; e.insn = exp_insn; e.err = exp_err;
        sb_q.push_back(e);
        #1;
        n_checks++;
        assert (sb_q.size() != 0) else begin
            $error("FAIL %s: scoreboard empty", tag);
        end
        if (sb_q.size() != 0) begin
            n_pass++;
            got = sb_q.pop_front();
            n_checks++;
            assert (instruction === got.insn) begin
                n_pass++;
            end else begin
                $error("FAIL %s.insn addr=%h observed=%h expected=%h",
                       got.tag, a, instruction, got.insn);
            end
            n_checks++;
            assert (addr_err === got.err) begin
                n_pass++;
            end else begin
                $error("FAIL %s.err addr=%h observed=%b expected=%b",
                       got.tag, a, addr_err, got.err);
            end
        end
        $display("fetch %-14s addr=%h insn=%h err=%b", tag, a, instruction, addr_err);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            fetch(tag, 32'(i * 4), model_mem[i], 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        we       = 1'b0;
        waddr    = 32'h0;
        wdata    = 32'h0;
        addr     = 32'h0;
        model_reset();

        fetch("rst_addr0", 32'h0000_0000, 32'h0, 1'b0);
        fetch("rst_oob",   32'h0000_0101, 32'h0, 1'b0);

`ifdef IMEM_LOAD_PORT_EN
        // Write attempted while in reset must be ignored.
        we = 1'b1; waddr = 32'h4; wdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        we = 1'b0;
`endif

        @(negedge clk);
        rst_n = 1'b1;
        fetch("boot0",     32'h0000_0000, 32'h0050_0093, 1'b0);
        fetch("boot1",     32'h0000_0004, 32'h00A0_0113, 1'b0);
        fetch("boot2",     32'h0000_0008, 32'h0020_81B3, 1'b0);
        fetch("boot3",     32'h0000_000C, 32'h0000_0013, 1'b0);
        fetch("misalign",  32'h0000_0006, 32'h00A0_0113, 1'b1);
        fetch("misalign3", 32'h0000_000B, 32'h0020_81B3, 1'b1);
        fetch("oob_edge",  32'h0000_0100, 32'h0000_0013, 1'b1);
        fetch("oob_high",  32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
        fetch("last_word", 32'h0000_00FC, 32'h0000_0013, 1'b0);
        sweep("boot_sweep");

`ifdef IMEM_LOAD_PORT_EN
        @(negedge clk);
        we = 1'b1; waddr = 32'h10; wdata = 32'hDEAD_BEEF;
        fetch("wr_before", 32'h0000_0010, 32'h0000_0013, 1'b0);
        @(posedge clk); #1;
        we = 1'b0;
        model_mem[4] = 32'hDEAD_BEEF;
        fetch("wr_after",  32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

        @(negedge clk);
        we = 1'b1; waddr = 32'h100; wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        we = 1'b0;
        sweep("oob_wr_sweep");

        @(negedge clk);
        we = 1'b1; waddr = 32'hFC; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        we = 1'b0;
        model_mem[63] = 32'hCAFE_F00D;
        fetch("wr_last",   32'h0000_00FC, 32'hCAFE_F00D, 1'b0);

        // waddr[1:0] is ignored, so 0x3 targets word 0.
        @(negedge clk);
        we = 1'b1; waddr = 32'h3; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        we = 1'b0;
        model_mem[0] = 32'h1234_5678;
        fetch("wr_word0",  32'h0000_0000, 32'h1234_5678, 1'b0);
`else
        @(negedge clk);
        we = 1'b1; waddr = 32'h0; wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        we = 1'b0;
        fetch("rom_word0", 32'h0000_0000, 32'h0050_0093, 1'b0);
        sweep("rom_sweep");
`endif

        // Asynchronous reset pulse between clock edges.
        @(posedge clk); #3;
        rst_n = 1'b0;
        fetch("async_rst", 32'h0000_0000, 32'h0, 1'b0);
        rst_n = 1'b1;
        model_reset();
        fetch("post_rst0", 32'h0000_0000, 32'h0050_0093, 1'b0);
        sweep("post_rst_sweep");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
Instruction memory for the RV32I core. The PC-driven fetch address is decoded into a word index, and the selected 32-bit instruction is returned combinationally. Storage is a flop-based array that is reset asynchronously to a built-in boot program. A synchronous load port lets a loader or bench overwrite words.

Parameters:
DEPTH, 64, number of 32-bit words (power of two, at least 4)
IDX_W, $clog2(DEPTH), word-index width (derived; not overridden)

Ports:
clk  in  1  single clock; the only edge-sensitive timing reference
rst_n  in  1  asynchronous, active-low reset
addr  in  32  byte fetch address from the PC
instruction  out  32  fetched instruction word
addr_err  out  1  fetch address misaligned or out of range
we  in  1  load-port write enable
waddr  in  32  load-port byte address
wdata  in  32  load-port write data

Behaviour:
- Reset image, loaded asynchronously while rst_n=0:
  - word0 = 0x00500093 (addi x1,x0,5)
  - word1 = 0x00A00113 (addi x2,x0,10)
  - word2 = 0x002081B3 (add x3,x1,x2)
  - all remaining words = 0x00000013 (NOP)
- While rst_n=0:
  - instruction = 0x00000000 and addr_err = 0, regardless of addr.
  - Writes are ignored.
- Read path is fully combinational, with zero latency from addr to instruction:
  - Index = addr[IDX_W+1:2]; addr[1:0] is ignored for selection.
  - If addr >= 4*DEPTH: instruction = 0x00000013 (NOP).
  - Otherwise: instruction = mem[index].
- addr_err (combinational) = (addr[1:0] != 0) OR (addr >= 4*DEPTH), when not in reset.
- Write, on the rising clk edge with rst_n=1 and we=1:
  - mem[waddr[IDX_W+1:2]] <= wdata.
  - waddr[1:0] is ignored.
  - If waddr >= 4*DEPTH the write is dropped; no wrap-around.
- Write and read to the same word in the same cycle: instruction shows the old data until the edge and the new data after it. There is no bypass.
- Reset asserted mid-operation: contents revert immediately to the reset image and the output goes to 0. A pending write on that edge is lost.
- Deassertion of rst_n takes effect without a clock edge. The read output becomes valid combinationally once rst_n=1.

Optional Feature:
IMEM_LOAD_PORT_EN
- Defined: the write port behaves as specified above.
- Undefined: we, waddr and wdata remain in the port list but are ignored. The memory holds the reset image permanently and is synthesized as a ROM: constant words, no flops except where the tool requires them.

Decomposition:
- Package instr_mem_pkg holds:
  - NOP_INSN = 32'h00000013
  - BOOT_LEN = 3
  - the boot program word constants (0x00500093, 0x00A00113, 0x002081B3)
  - a function boot_word(idx) that returns the boot image word for a given index (NOP beyond BOOT_LEN)
- No sub-module is required. The storage array, read mux and write decode stay in instr_mem.

Test Plan:
- rst_n=0, addr=0x0 -> instruction=0x00000000, addr_err=0.
- Release reset; addr=0x00/0x04/0x08/0x0C -> 0x00500093 / 0x00A00113 / 0x002081B3 / 0x00000013, addr_err=0.
- addr=0x06 -> instruction=0x00A00113, addr_err=1. addr=4*DEPTH (0x100) -> instruction=0x00000013, addr_err=1.
- With IMEM_LOAD_PORT_EN: we=1, waddr=0x10, wdata=0xDEADBEEF with addr=0x10 -> 0x00000013 before the edge, 0xDEADBEEF after it. A write to waddr=0x100 leaves all words unchanged.
- Overwrite word0 with 0x12345678, then pulse rst_n low asynchronously between clock edges -> instruction=0 immediately. After release, addr=0x0 -> 0x00500093.
- Without IMEM_LOAD_PORT_EN: we=1, waddr=0x0, wdata=0xFFFFFFFF, clock once -> addr=0x0 still returns 0x00500093.
